// File: rtl/reg_file_sb_pkg.sv
// Shared types and constants for the core register file and its busy-bit scoreboard.
// Decode also uses ZERO_REG and ID_REG.
package reg_file_sb_pkg;

  localparam int N_REGS = 16;

  typedef logic [$clog2(N_REGS)-1:0] reg_addr_t;
  typedef logic [31:0]               core_word_t;
  typedef core_word_t                core_id_t;

  localparam reg_addr_t ZERO_REG = '0;
  localparam reg_addr_t ID_REG   = reg_addr_t'(N_REGS - 1);

  // The zero and ID registers are read-only. Addresses past the end exist only when
  // nregs is not a power of two.
  function automatic logic addr_writable(input int addr, input int nregs);
    return (addr != 0) && (addr < nregs - 1);
  endfunction

  function automatic logic addr_readable(input int addr, input int nregs);
    return addr < nregs;
  endfunction

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// Busy-bit scoreboard. It holds one pending-producer flag per register: claim sets the
// flag, a write clears it, and flush clears every flag.
module reg_scoreboard
  import reg_file_sb_pkg::*;
#(
  parameter int NREGS  = N_REGS,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int AW     = $clog2(NREGS),
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] raddr,
  input  logic [NWR-1:0]    we,
  input  logic [NWR*AW-1:0] waddr,
  input  logic              claim,
  input  logic [AW-1:0]     claim_addr,
  input  logic              flush,
  output logic [NRD-1:0]    rbusy
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;

  // The sequence is flush, then clears from writes, then the claim. A claim therefore wins
  // over both, because it stands for a newer producer.
  always_comb begin
    busy_nxt = flush ? '0 : busy;
    for (int j = 0; j < NWR; j++) begin
      if (we[j] && addr_writable(int'(waddr[j*AW +: AW]), NREGS))
        busy_nxt[waddr[j*AW +: AW]] = 1'b0;
    end
    if (claim && addr_writable(int'(claim_addr), NREGS))
      busy_nxt[claim_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  always_comb begin
    rbusy = '0;
    for (int i = 0; i < NRD; i++) begin
      logic hit;
      hit = 1'b0;
      for (int j = 0; j < NWR; j++) begin
        if (we[j] && (waddr[j*AW +: AW] == raddr[i*AW +: AW])) hit = 1'b1;
      end
      if (addr_readable(int'(raddr[i*AW +: AW]), NREGS))
        rbusy[i] = busy[raddr[i*AW +: AW]] && !((BYPASS != 0) && hit);
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with write->read bypass and an integrated busy-bit scoreboard.
// Register 0 always reads zero. Register NREGS-1 always reads core_id.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int WIDTH  = $bits(core_word_t),
  parameter int NREGS  = N_REGS,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     core_id,
  input  logic [NRD*AW-1:0]    raddr,
  output logic [NRD*WIDTH-1:0] rdata,
  output logic [NRD-1:0]       rbusy,
  input  logic [NWR-1:0]       we,
  input  logic [NWR*AW-1:0]    waddr,
  input  logic [NWR*WIDTH-1:0] wdata,
  input  logic                 claim,
  input  logic [AW-1:0]        claim_addr,
  input  logic                 flush
);

  localparam logic [AW-1:0] ID_A = AW'(NREGS - 1);

  logic [WIDTH-1:0] regs [NREGS];

  // The ports are scanned in ascending order, so the highest-index port wins a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREGS; k++) regs[k] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (we[j] && addr_writable(int'(waddr[j*AW +: AW]), NREGS))
          regs[waddr[j*AW +: AW]] <= wdata[j*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NRD; i++) begin
      logic [AW-1:0] a;
      a = raddr[i*AW +: AW];
      if (a == AW'(ZERO_REG)) begin
        rdata[i*WIDTH +: WIDTH] = '0;
      end else if (a == ID_A) begin
        rdata[i*WIDTH +: WIDTH] = core_id;
      end else if (addr_readable(int'(a), NREGS)) begin
        rdata[i*WIDTH +: WIDTH] = regs[a];
        if (BYPASS != 0) begin
          for (int j = 0; j < NWR; j++) begin
            if (we[j] && (waddr[j*AW +: AW] == a))
              rdata[i*WIDTH +: WIDTH] = wdata[j*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

  reg_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR),
    .AW    (AW),
    .BYPASS(BYPASS)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .raddr     (raddr),
    .we        (we),
    .waddr     (waddr),
    .claim     (claim),
    .claim_addr(claim_addr),
    .flush     (flush),
    .rbusy     (rbusy)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb. A bypassing and a non-bypassing instance share stimulus and are
// checked against an array-based reference model.
module tb_reg_file_sb;

  localparam int W  = 32;
  localparam int NR = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  core_id;
  logic [7:0]    raddr;
  logic [63:0]   rdata_b, rdata_n;
  logic [1:0]    rbusy_b, rbusy_n;
  logic [1:0]    we;
  logic [7:0]    waddr;
  logic [63:0]   wdata;
  logic          claim;
  logic [3:0]    claim_addr;
  logic          flush;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  logic [W-1:0] m_regs [NR];
  bit           m_busy [NR];

  always #5 clk = ~clk;

  reg_file_sb #(.BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .core_id(core_id), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
    .we(we), .waddr(waddr), .wdata(wdata), .claim(claim), .claim_addr(claim_addr), .flush(flush)
  );

  reg_file_sb #(.BYPASS(0)) u_nob (
    .clk(clk), .rst(rst), .core_id(core_id), .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
    .we(we), .waddr(waddr), .wdata(wdata), .claim(claim), .claim_addr(claim_addr), .flush(flush)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // The value decode should see: the newest same-cycle write when bypassing, else the stored value.
  function automatic logic [W-1:0] exp_rd(input int a, input bit byp);
    if (a == 0) return '0;
    if (a == NR - 1) return core_id;
    if (byp) begin
      if (we[1] && int'(waddr[7:4]) == a) return wdata[63:32];
      if (we[0] && int'(waddr[3:0]) == a) return wdata[31:0];
    end
    return m_regs[a];
  endfunction

  function automatic logic [W-1:0] exp_busy(input int a, input bit byp);
    bit written;
    written = (we[0] && int'(waddr[3:0]) == a) || (we[1] && int'(waddr[7:4]) == a);
    return {31'b0, m_busy[a] && !(byp && written)};
  endfunction

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      int a;
      a = int'(raddr[i*AW +: AW]);
      check($sformatf("rd_byp%0d", i), rdata_b[i*W +: W], exp_rd(a, 1'b1));
      check($sformatf("rd_nob%0d", i), rdata_n[i*W +: W], exp_rd(a, 1'b0));
      check($sformatf("busy_byp%0d", i), {31'b0, rbusy_b[i]}, exp_busy(a, 1'b1));
      check($sformatf("busy_nob%0d", i), {31'b0, rbusy_n[i]}, exp_busy(a, 1'b0));
    end
  endtask

  task automatic model_update();
    if (rst) begin
      for (int k = 0; k < NR; k++) begin
        m_regs[k] = '0;
        m_busy[k] = 1'b0;
      end
    end else begin
      int wa0, wa1, ca;
      wa0 = int'(waddr[3:0]);
      wa1 = int'(waddr[7:4]);
      ca  = int'(claim_addr);
      if (we[1] && wa1 != 0 && wa1 != NR - 1) m_regs[wa1] = wdata[63:32];
      if (we[0] && wa0 != 0 && wa0 != NR - 1 && !(we[1] && wa1 == wa0)) m_regs[wa0] = wdata[31:0];
      if (flush) for (int k = 0; k < NR; k++) m_busy[k] = 1'b0;
      if (we[0]) m_busy[wa0] = 1'b0;
      if (we[1]) m_busy[wa1] = 1'b0;
      if (claim && ca != 0 && ca != NR - 1) m_busy[ca] = 1'b1;
    end
  endtask

  // Inputs are set just after a posedge, checked at the negedge, and then committed.
  task automatic step();
    #4;
    if (chk_en) check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; we = '0; waddr = '0; wdata = '0; claim = 1'b0; claim_addr = '0; flush = 1'b0;
  endtask

  task automatic drive_write(input int port, input int a, input logic [W-1:0] d);
    we[port] = 1'b1;
    waddr[port*AW +: AW] = AW'(a);
    wdata[port*W +: W] = d;
  endtask

  task automatic set_reads(input int a0, input int a1);
    raddr = {AW'(a1), AW'(a0)};
  endtask

  initial begin
    core_id = 32'h5;
    idle();
    set_reads(0, 0);
    rst = 1'b1;
    step();
    step();
    chk_en = 1'b1;

    // Reset drops an older write, and a write made during reset.
    idle(); set_reads(3, 4);
    drive_write(0, 3, 32'hDEAD);
    step();
    idle(); rst = 1'b1; drive_write(0, 4, 32'h1234);
    step();
    idle(); set_reads(3, 4); #1;
    check("rst_r3", rdata_b[31:0], 32'h0);
    check("rst_r4", rdata_b[63:32], 32'h0);
    set_reads(15, 15); #1;
    check("rst_id", rdata_n[31:0], 32'h5);
    check("rst_busy", {30'b0, rbusy_b}, 32'h0);
    step();

    // Write collision.
    idle(); set_reads(5, 5);
    drive_write(0, 5, 32'h11); drive_write(1, 5, 32'h22); #1;
    check("coll_bypass", rdata_b[31:0], 32'h22);
    step();
    idle(); set_reads(5, 5); #1;
    check("coll_byp", rdata_b[31:0], 32'h22);
    check("coll_nob", rdata_n[63:32], 32'h22);
    step();

    // Protected registers.
    idle(); set_reads(0, 15);
    drive_write(0, 0, 32'hFF); drive_write(1, 15, 32'hFF); claim = 1'b1; claim_addr = 4'd0; #1;
    check("prot_r0_same", rdata_b[31:0], 32'h0);
    check("prot_id_same", rdata_b[63:32], 32'h5);
    step();
    idle(); set_reads(0, 15); #1;
    check("prot_r0", rdata_n[31:0], 32'h0);
    check("prot_id", rdata_n[63:32], 32'h5);
    check("prot_busy", {30'b0, rbusy_b}, 32'h0);
    step();

    // Claim, then a write that clears the claim.
    idle(); set_reads(7, 7); claim = 1'b1; claim_addr = 4'd7;
    step();
    idle(); set_reads(7, 7); #1;
    check("sb_busy_byp", {31'b0, rbusy_b[0]}, 32'h1);
    check("sb_busy_nob", {31'b0, rbusy_n[0]}, 32'h1);
    drive_write(0, 7, 32'h9); #1;
    check("sb_wr_busy_byp", {31'b0, rbusy_b[0]}, 32'h0);
    check("sb_wr_data_byp", rdata_b[31:0], 32'h9);
    check("sb_wr_busy_nob", {31'b0, rbusy_n[0]}, 32'h1);
    step();
    idle(); set_reads(7, 7); #1;
    check("sb_after_nob", {31'b0, rbusy_n[0]}, 32'h0);
    check("sb_after_data", rdata_n[31:0], 32'h9);
    step();

    // A claim and a write to the same register in the same cycle.
    idle(); set_reads(2, 2); drive_write(0, 2, 32'h77); claim = 1'b1; claim_addr = 4'd2;
    step();
    idle(); set_reads(2, 2); #1;
    check("cw_data", rdata_b[31:0], 32'h77);
    check("cw_busy_byp", {31'b0, rbusy_b[0]}, 32'h1);
    check("cw_busy_nob", {31'b0, rbusy_n[0]}, 32'h1);
    step();

    // A flush with a claim in the same cycle.
    idle(); drive_write(0, 4, 32'h44); drive_write(1, 6, 32'h66); step();
    idle(); claim = 1'b1; claim_addr = 4'd4; step();
    idle(); claim = 1'b1; claim_addr = 4'd6; step();
    idle(); flush = 1'b1; claim = 1'b1; claim_addr = 4'd9; step();
    idle(); set_reads(4, 6); #1;
    check("fl_busy4", {31'b0, rbusy_b[0]}, 32'h0);
    check("fl_busy6", {31'b0, rbusy_b[1]}, 32'h0);
    check("fl_data4", rdata_b[31:0], 32'h44);
    check("fl_data6", rdata_n[63:32], 32'h66);
    set_reads(9, 2); #1;
    check("fl_busy9", {31'b0, rbusy_b[0]}, 32'h1);
    check("fl_busy2", {31'b0, rbusy_n[1]}, 32'h0);
    step();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      idle();
      rst = ($urandom_range(0, 63) == 0);
      we = 2'($urandom_range(0, 3));
      waddr = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
      if ($urandom_range(0, 3) == 0) waddr[7:4] = waddr[3:0];
      wdata = {$urandom, $urandom};
      claim = ($urandom_range(0, 2) == 0);
      claim_addr = 4'($urandom_range(0, 15));
      flush = ($urandom_range(0, 15) == 0);
      raddr = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
      if ($urandom_range(0, 2) == 0) raddr[3:0] = waddr[3:0];
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
